// File: rtl/stage_sequencer_pkg.sv
// Shared types for the stage sequencer: FSM state and latched run mode.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } seq_state_t;

    typedef enum logic {
        AUTO   = 1'b0,
        MANUAL = 1'b1
    } seq_mode_t;

endpackage

// File: rtl/stage_sequencer_if.sv
// Front-panel requests in, per-stage enables and status out; directions named from the sequencer side.
interface stage_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    localparam int unsigned STG_W = $clog2(NUM_STAGES);

    logic                  auto_i;
    logic                  manual_i;
    logic [NUM_STAGES-1:0] step_i;
    logic                  abort_i;
    logic [NUM_STAGES-1:0] en_o;
    logic [NUM_STAGES-1:0] led_o;
    logic [STG_W-1:0]      stage_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output auto_i, manual_i, step_i, abort_i,
        input  en_o, led_o, stage_o, busy_o, done_o
    );

    modport slave (
        input  auto_i, manual_i, step_i, abort_i,
        output en_o, led_o, stage_o, busy_o, done_o
    );

endinterface

// File: rtl/stage_sequencer_dwell_timer.sv
// Saturating dwell counter with synchronous clear and an equality flag against a run-time compare value.
module dwell_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             cnt_en_i,
    input  logic [CNT_W-1:0] cmp_val_i,
    output logic             hit_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_c_o = (cnt_q == cmp_val_i);

endmodule

// File: rtl/stage_sequencer.sv
// N-stage sequencer: walks a one-hot enable through the stages, timed or operator-stepped,
// then holds the last stage for a fixed time before returning to idle with a done pulse.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned AUTO_DWELL = 20,
    parameter int unsigned FINAL_HOLD = 5
) (
    input  logic               clk,
    input  logic               rst,
    stage_sequencer_if.slave   bus
);

    localparam int unsigned      STG_W    = $clog2(NUM_STAGES);
    localparam logic [STG_W-1:0] LAST_IDX = STG_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] RUN_CMP  = CNT_W'(AUTO_DWELL - 1);
    localparam logic [CNT_W-1:0] HOLD_CMP = CNT_W'(FINAL_HOLD - 1);

    seq_state_t            state_q, state_d;
    seq_mode_t             mode_q,  mode_d;
    logic [STG_W-1:0]      stage_q, stage_d;
    logic [NUM_STAGES-1:0] en_q,    en_d;
    logic [NUM_STAGES-1:0] led_q,   led_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic             clr_c;
    logic             cnt_en_c;
    logic             hit_c;
    logic [CNT_W-1:0] cmp_c;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_c),
        .cnt_en_i  (cnt_en_c),
        .cmp_val_i (cmp_c),
        .hit_c_o   (hit_c)
    );

    // Next state, counter control and next-cycle output decode.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        stage_d  = stage_q;
        done_d   = 1'b0;
        clr_c    = 1'b0;
        cnt_en_c = ((state_q == RUN) && (mode_q == AUTO)) || (state_q == LAST);
        cmp_c    = (state_q == LAST) ? HOLD_CMP : RUN_CMP;

        unique case (state_q)
            IDLE: begin
                clr_c = 1'b1;
                if (bus.auto_i) begin
                    state_d = RUN;
                    stage_d = '0;
                    mode_d  = AUTO;
                end else if (bus.manual_i && !bus.step_i[0]) begin
                    // A step[0] already held would otherwise skip stage 0 immediately.
                    state_d = RUN;
                    stage_d = '0;
                    mode_d  = MANUAL;
                end
            end
            RUN: begin
                if ((mode_q == AUTO) ? hit_c : bus.step_i[stage_q]) begin
                    stage_d = stage_q + STG_W'(1);
                    clr_c   = 1'b1;
                    if (stage_d == LAST_IDX) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                if (hit_c) begin
                    state_d = IDLE;
                    stage_d = '0;
                    done_d  = 1'b1;
                    clr_c   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase

        if (bus.abort_i) begin
            state_d = IDLE;
            stage_d = '0;
            done_d  = 1'b0;
            clr_c   = 1'b1;
        end

        en_d   = '0;
        led_d  = '0;
        busy_d = (state_d != IDLE);
        if (busy_d) begin
            en_d  = NUM_STAGES'(1) << stage_d;
            led_d = en_d | (en_d - NUM_STAGES'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= AUTO;
            stage_q <= '0;
            en_q    <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            en_q    <= en_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.en_o    = en_q;
    assign bus.led_o   = led_q;
    assign bus.stage_o = stage_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer at NUM_STAGES=4, AUTO_DWELL=20, FINAL_HOLD=5.
module tb_stage_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [3:0] en_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] led_tab [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    stage_sequencer_if #(.NUM_STAGES(4)) bus ();

    stage_sequencer #(
        .NUM_STAGES (4),
        .CNT_W      (8),
        .AUTO_DWELL (20),
        .FINAL_HOLD (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_en, input logic [3:0] e_led,
                             input logic [1:0] e_stg, input logic e_busy, input logic e_done);
        chk({tag, ".en"},    32'(bus.en_o),    32'(e_en));
        chk({tag, ".led"},   32'(bus.led_o),   32'(e_led));
        chk({tag, ".stage"}, 32'(bus.stage_o), 32'(e_stg));
        chk({tag, ".busy"},  32'(bus.busy_o),  32'(e_busy));
        chk({tag, ".done"},  32'(bus.done_o),  32'(e_done));
    endtask

    task automatic check_idle(input string tag, input logic e_done);
        check_out(tag, 4'b0000, 4'b0000, 2'd0, 1'b0, e_done);
    endtask

    // Checks n consecutive cycles showing stage k, advancing one negedge after each.
    task automatic check_stage(input string tag, input int k, input int n);
        for (int i = 0; i < n; i++) begin
            check_out(tag, en_tab[k], led_tab[k], 2'(k), 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total       = 0;
        bad         = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        bus.auto_i   = 1'b0;
        bus.manual_i = 1'b0;
        bus.step_i   = 4'b0000;
        bus.abort_i  = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check_idle("rst_hold", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_rel", 1'b0);

        // full auto sequence from a one-cycle pulse
        bus.auto_i = 1'b1;
        @(negedge clk);
        bus.auto_i = 1'b0;
        check_stage("auto_s0", 0, 20);
        check_stage("auto_s1", 1, 20);
        check_stage("auto_s2", 2, 20);
        check_stage("auto_s3", 3, 5);
        check_idle("auto_done", 1'b1);
        @(negedge clk);
        check_idle("auto_after", 1'b0);

        // manual stepping, step[0] held across stage 1, mode ignores manual dropping
        bus.manual_i = 1'b1;
        @(negedge clk);
        check_stage("man_s0", 0, 25);
        bus.step_i = 4'b0001;
        @(negedge clk);
        bus.manual_i = 1'b0;
        check_stage("man_s1_hold", 1, 5);
        bus.step_i = 4'b0010;
        @(negedge clk);
        bus.step_i = 4'b0100;
        check_stage("man_s2", 2, 1);
        bus.step_i = 4'b1000;
        check_stage("man_s3", 3, 5);
        bus.step_i = 4'b0000;
        check_idle("man_done", 1'b1);
        @(negedge clk);
        check_idle("man_after", 1'b0);

        // manual with step[0] already high is not a start
        bus.manual_i = 1'b1;
        bus.step_i   = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_idle("skip_block", 1'b0);
            @(negedge clk);
        end
        bus.step_i = 4'b0000;
        @(negedge clk);
        check_stage("skip_start", 0, 2);
        bus.abort_i  = 1'b1;
        bus.manual_i = 1'b0;
        @(negedge clk);
        check_idle("skip_abort", 1'b0);
        bus.abort_i = 1'b0;

        // abort in stage 2 with auto held, then restart
        bus.auto_i = 1'b1;
        @(negedge clk);
        check_stage("ab_s0", 0, 20);
        check_stage("ab_s1", 1, 20);
        check_stage("ab_s2", 2, 5);
        bus.abort_i = 1'b1;
        @(negedge clk);
        check_idle("ab_idle", 1'b0);
        bus.abort_i = 1'b0;
        @(negedge clk);
        bus.auto_i = 1'b0;
        check_stage("ab_restart", 0, 20);
        check_stage("rs_s1", 1, 3);

        // asynchronous reset mid stage 1
        #2 rst = 1'b1;
        #1 check_idle("arst_now", 1'b0);
        @(negedge clk);
        check_idle("arst_hold", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("arst_rel", 1'b0);

        // auto wins over manual; dropping manual mid-run keeps timed mode
        bus.auto_i   = 1'b1;
        bus.manual_i = 1'b1;
        @(negedge clk);
        bus.auto_i = 1'b0;
        check_stage("both_s0a", 0, 10);
        bus.manual_i = 1'b0;
        check_stage("both_s0b", 0, 10);
        check_stage("both_s1", 1, 20);
        check_stage("both_s2", 2, 20);
        check_stage("both_s3", 3, 5);
        check_idle("both_done", 1'b1);
        @(negedge clk);
        check_idle("both_after", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised N-stage sequencer: walks a one-hot enable through `NUM_STAGES` stages and drives a thermometer status bar. It runs either timed (auto) or operator-stepped (manual), and finishes with a fixed hold on the last stage. All timing is done with a synthesizable dwell counter. It sits between the front-panel switch/debounce logic and the per-stage actuator enables and LEDs.

## Interface
- `NUM_STAGES`, 4: number of stages; must be ≥2.
- `CNT_W`, 8: dwell counter width; 2^CNT_W ≥ max(AUTO_DWELL, FINAL_HOLD).
- `AUTO_DWELL`, 20: cycles spent in each non-final stage in auto mode; ≥1.
- `FINAL_HOLD`, 5: cycles spent in the final stage in both modes; ≥1.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `auto` in 1: start request, timed mode (level).
- `manual` in 1: start request, stepped mode (level).
- `step` in NUM_STAGES: per-stage advance switch; `step[k]` advances out of stage k in manual mode.
- `abort` in 1: return to idle immediately (synchronous).
- `en` out NUM_STAGES: one-hot stage enable; all zero when idle.
- `led` out NUM_STAGES: thermometer; bits 0..stage set; all zero when idle.
- `stage` out $clog2(NUM_STAGES): current stage index; 0 when idle.
- `busy` out 1: high in any non-idle state.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- States (shared enum): IDLE, RUN, LAST. A stage index register and a mode register (AUTO/MANUAL) accompany the state.
- **IDLE:**
  - `auto`=1 → RUN, stage 0, mode AUTO.
  - Otherwise `manual`=1 and `step[0]`=0 → RUN, stage 0, mode MANUAL.
  - `manual` with `step[0]`=1 is ignored; this prevents skip-through.
  - `auto` has priority when both are high.
  - The dwell counter clears on entry.
- **RUN, stage k < NUM_STAGES-1:**
  - Advance condition in AUTO: dwell counter == AUTO_DWELL-1.
  - Advance condition in MANUAL: `step[k]`=1.
  - On advance: stage ← k+1 and counter cleared. If k+1 == NUM_STAGES-1, the state becomes LAST.
- **LAST:**
  - Counter == FINAL_HOLD-1 → IDLE, with `done`=1 in the following (first IDLE) cycle.
  - `step` inputs are ignored.
- Mode is latched at start. Changes on `auto`/`manual` during a run are ignored. Holding `step[k]` high advances only once, because the next stage needs `step[k+1]`.
- `abort`=1 in any state → IDLE at the next edge, counter cleared, no `done`. Abort has priority over advance and start.
- Outputs are Moore and registered, decoded from state plus the stage register: `en` = 1<<stage, `led` = (2<<stage)-1, `busy` = (state != IDLE).
- The counter saturates at 2^CNT_W-1 and never wraps. It only counts in RUN-AUTO and LAST.

## Timing
- On reset: state IDLE, stage 0, counter 0, mode AUTO; `en`, `led`, `stage`, `busy` and `done` all 0. Reset mid-run gives the same values with no `done`.
- Start latency: a request sampled at edge t gives `en[0]`=1 and `busy`=1 after edge t.
- Auto stage k is visible for exactly AUTO_DWELL cycles. The final stage is visible for exactly FINAL_HOLD cycles.
- Full auto sequence: (NUM_STAGES-1)·AUTO_DWELL + FINAL_HOLD busy cycles, then `done` for 1 cycle.
- Manual advance: `step[k]` high at edge t → stage k+1 visible after edge t.
- `abort` sampled at edge t: all outputs 0 after edge t.
- A new start is accepted in the cycle `done` is high. The sequence restarts if `auto` is still high.

## Structure
- Package `seq_pkg`: state enum `seq_state_t` (IDLE, RUN, LAST) and mode enum `seq_mode_t` (AUTO, MANUAL).
- Sub-module `dwell_timer` (CNT_W): synchronous clear, count enable, saturating count, compare-to-value flag.
- The top module holds the FSM, the stage/mode registers and the output decode.

## Test plan
Defaults: NUM_STAGES=4, AUTO_DWELL=20, FINAL_HOLD=5.
- Auto pulse for 1 cycle → `en` = 0001/0010/0100 for 20 cycles each, then 1000 for 5 cycles; `led` = 0001/0011/0111/1111; `done` pulse at cycle 66; `busy` for 65 cycles.
- Manual=1 with `step`=0000, then pulses on step[0], step[1], step[2] at cycles 10/30/31 → stage changes after each edge, final stage for 5 cycles, `done`=1. Holding step[0]=1 throughout stays at stage 1 until step[1].
- Manual=1 with step[0]=1 held from idle → stays IDLE, `busy`=0. Releasing step[0] starts the sequence.
- Auto run with `abort` in stage 2, cycle 45 → all outputs 0 next cycle, no `done`. Auto still high → restart at stage 0 the following cycle.
- `rst` asserted asynchronously mid-stage 1 → outputs 0 immediately, no `done`.
- `auto`=`manual`=1 simultaneously, then `manual` dropped mid-run → auto mode used throughout, total timing unchanged (65 cycles).
